dm_responder: RTL

DM_RESPONDER -- requirements
Module: dm_responder

---
 rtl/dm_responder_pkg.sv | 29 ++
 rtl/dm_lane_align.sv | 33 +++
 rtl/dm_responder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/dm_responder_pkg.sv
// Shared data-memory access encodings and responder FSM states, also imported by the CPU load/store unit.
package dm_responder_pkg;

  typedef enum logic [2:0] {
    DM_W  = 3'b000,
    DM_HS = 3'b001,
    DM_HU = 3'b010,
    DM_BS = 3'b011,
    DM_BU = 3'b100
  } dm_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dm_state_e;

  typedef struct packed {
    logic        we;
    logic [2:0]  dm_type;
    logic [31:0] addr;
    logic [31:0] din;
  } dm_req_t;

  function automatic logic dm_is_half(input logic [2:0] t);
    return (t == DM_HS) || (t == DM_HU);
  endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Load-path lane extraction: picks the addressed byte/half of a word and right-aligns it with sign or zero extension.
module dm_lane_align
  import dm_responder_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  dm_type,
  output logic [31:0] data
);

  logic [15:0] half;
  logic [7:0]  byt;

  always_comb begin
    half = lane[1] ? word[31:16] : word[15:0];
    case (lane)
      2'd0:    byt = word[7:0];
      2'd1:    byt = word[15:8];
      2'd2:    byt = word[23:16];
      default: byt = word[31:24];
    endcase
    data = '0;
    case (dm_type)
      DM_W:    data = word;
      DM_HS:   data = {{16{half[15]}}, half};
      DM_HU:   data = {16'b0, half};
      DM_BS:   data = {{24{byt[7]}}, byt};
      DM_BU:   data = {24'b0, byt};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: captures one request, waits WAIT_CYCLES, then answers with a one-cycle ack.
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 128,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  dm_type,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic        busy,
  output logic        ack,
  output logic [31:0] dout,
  output logic        err
);

  localparam int         IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  dm_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  dm_req_t     req_q;
  logic        accept, resp;

  logic [31:0] mem [DEPTH_WORDS];
  logic [IDX_W-1:0] idx;
  logic        mis, oor, bad, flag, mem_we;
  logic [3:0]  be;
  logic [31:0] wdata, rd_word, ld_data;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    resp    = 1'b0;
    case (state_q)
      ST_IDLE: if (req) begin
        accept  = 1'b1;
        cnt_d   = WAIT_INIT;
        state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_RESP;
      end
      ST_RESP: begin
        resp    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request checks are made on the captured request only, so bus activity while busy is irrelevant.
  assign idx  = req_q.addr[IDX_W+1:2];
  assign mis  = ((req_q.dm_type == DM_W) && (req_q.addr[1:0] != 2'b00)) ||
                (dm_is_half(req_q.dm_type) && req_q.addr[0]);
  assign oor  = {2'b00, req_q.addr[31:2]} >= 32'(DEPTH_WORDS);
  assign bad  = req_q.dm_type > 3'd4;
  assign flag = mis | oor | bad;

  always_comb begin
    be    = 4'h0;
    wdata = '0;
    case (req_q.dm_type)
      DM_W: begin
        be    = 4'hF;
        wdata = req_q.din;
      end
      DM_HS, DM_HU: begin
        be    = req_q.addr[1] ? 4'hC : 4'h3;
        wdata = {2{req_q.din[15:0]}};
      end
      DM_BS, DM_BU: begin
        be    = 4'b0001 << req_q.addr[1:0];
        wdata = {4{req_q.din[7:0]}};
      end
      default: be = 4'h0;
    endcase
  end

  assign mem_we  = resp & req_q.we & ~flag;
  assign rd_word = oor ? '0 : mem[idx];

  always_ff @(posedge clk) begin
    if (mem_we)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
  end

  dm_lane_align u_align (
    .word    (rd_word),
    .lane    (req_q.addr[1:0]),
    .dm_type (req_q.dm_type),
    .data    (ld_data)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy  <= 1'b0;
      ack   <= 1'b0;
      err   <= 1'b0;
      dout  <= '0;
      req_q <= '0;
    end else begin
      ack  <= resp;
      err  <= resp & flag;
      dout <= (resp && !flag && !req_q.we) ? ld_data : '0;
      if (accept) begin
        busy  <= 1'b1;
        req_q <= '{we: we, dm_type: dm_type, addr: addr, din: din};
      end else if (resp) begin
        busy  <= 1'b0;
      end
    end
  end

endmodule
